// File: rtl/taxi_eth_phy_rx_ber_mon_ml_if.sv
// Receive-side sync-header bus for the multi-lane BER monitor: per-lane
// headers, header qualifiers and the lane enable mask.
interface taxi_eth_phy_rx_ber_mon_ml_if #(
    parameter int LANES = 1,
    parameter int HDR_W = 2
);
    logic [LANES*HDR_W-1:0] serdes_rx_hdr;
    logic [LANES-1:0]       serdes_rx_hdr_valid;
    logic [LANES-1:0]       cfg_lane_en;

    modport master (
        output serdes_rx_hdr,
        output serdes_rx_hdr_valid,
        output cfg_lane_en
    );

    modport slave (
        input serdes_rx_hdr,
        input serdes_rx_hdr_valid,
        input cfg_lane_en
    );
endinterface

// File: rtl/taxi_eth_phy_rx_ber_mon_ml.sv
// Multi-lane BASE-R BER monitor: windowed invalid sync-header count and sticky high-BER flag.
// Define TAXI_ETH_PHY_RX_BER_MON_STATS_EN to build the cumulative error statistic counter.
module taxi_eth_phy_rx_ber_mon_ml #(
    parameter int  LANES        = 1,
    parameter int  HDR_W        = 2,
    parameter real COUNT_WINDOW = 125000/6.4,
    parameter int  BER_THRESH   = 16,
    parameter int  STAT_W       = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    taxi_eth_phy_rx_ber_mon_ml_if.slave        rx_bus,
    output logic                               rx_high_ber,
    output logic [7:0]                         rx_ber_cnt,
    output logic [STAT_W-1:0]                  stat_err_cnt,
    input  logic                               stat_clr
);

    localparam int CW = $rtoi(COUNT_WINDOW);
    localparam int TW = $clog2(CW + 1);

    if (HDR_W != 2) begin : g_hdr_w_check
        $fatal(1, "HDR_W must be 2");
    end
    if (LANES < 1 || LANES > 8) begin : g_lanes_check
        $fatal(1, "LANES must be 1..8");
    end
    if (CW < 1) begin : g_cw_check
        $fatal(1, "COUNT_WINDOW must be >= 1");
    end
    if (BER_THRESH < 1 || BER_THRESH > 255) begin : g_thresh_check
        $fatal(1, "BER_THRESH must be 1..255");
    end

    function automatic logic [7:0] sat_thresh(input logic [8:0] s);
        if (s >= 9'(BER_THRESH)) return 8'(BER_THRESH);
        return s[7:0];
    endfunction

    logic [LANES-1:0] qual_p0;
    logic [LANES-1:0] err_p0;
    logic [3:0]       e_p0;
    logic [8:0]       sum_p0;
    logic             over_p0;
    logic             expiry_p0;

    logic [TW-1:0]    timer_p1;
    logic [7:0]       ber_cnt_p1;
    logic             high_p1;

    // Stage 0: lane qualification, header check and per-cycle error count
    always_comb begin
        qual_p0 = rx_bus.serdes_rx_hdr_valid & rx_bus.cfg_lane_en;
        err_p0  = '0;
        e_p0    = '0;
        for (int n = 0; n < LANES; n++) begin
            err_p0[n] = qual_p0[n] &
                        (rx_bus.serdes_rx_hdr[n*2 +: 2] == 2'b00 ||
                         rx_bus.serdes_rx_hdr[n*2 +: 2] == 2'b11);
            e_p0 = e_p0 + {3'b000, err_p0[n]};
        end
        sum_p0    = {1'b0, ber_cnt_p1} + {5'b00000, e_p0};
        over_p0   = sum_p0 >= 9'(BER_THRESH);
        // A window only closes on a cycle that carries a qualified header.
        expiry_p0 = (timer_p1 == '0) & (|qual_p0);
    end

    // Stage 1: window timer, windowed count and sticky high-BER flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_p1   <= TW'(CW);
            ber_cnt_p1 <= '0;
            high_p1    <= 1'b0;
        end else if (expiry_p0) begin
            timer_p1   <= TW'(CW);
            ber_cnt_p1 <= '0;
            high_p1    <= over_p0;
        end else begin
            if (timer_p1 != '0) timer_p1 <= timer_p1 - TW'(1);
            ber_cnt_p1 <= sat_thresh(sum_p0);
            if (over_p0) high_p1 <= 1'b1;
        end
    end

    assign rx_high_ber = high_p1;
    assign rx_ber_cnt  = ber_cnt_p1;

`ifdef TAXI_ETH_PHY_RX_BER_MON_STATS_EN
    function automatic logic [STAT_W-1:0] sat_stat(input logic [STAT_W-1:0] base,
                                                   input logic [3:0] inc);
        logic [STAT_W+3:0] t;
        t = {4'b0000, base} + {{STAT_W{1'b0}}, inc};
        if (|t[STAT_W+3:STAT_W]) return '1;
        return t[STAT_W-1:0];
    endfunction

    // Clear loads this cycle's errors so none are lost on the clear cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_err_cnt <= '0;
        end else if (stat_clr) begin
            stat_err_cnt <= sat_stat('0, e_p0);
        end else begin
            stat_err_cnt <= sat_stat(stat_err_cnt, e_p0);
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign stat_err_cnt    = '0;
`endif

endmodule
